// File: rtl/operand2_pipe.sv
// ============================================================================
// Module      : operand2_pipe
// Description : Forms the ALU second operand from R, Imm and Is behind a
//               valid/ready stage with a two-entry skid buffer and a tag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand2_pipe #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 22,
    parameter int SIMM_W = 13,
    parameter int SHC_W  = 5,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_R,
    input  logic [IMM_W-1:0]  in_Imm,
    input  logic [3:0]        in_Is,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_N,
    output logic [TAG_W-1:0]  out_tag
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              rdy_q, rdy_d;
    logic [DATA_W-1:0] out_n_q, skid_n_q;
    logic [TAG_W-1:0]  out_tag_q, skid_tag_q;

    logic [DATA_W-1:0] form_n;
    logic              accept, xfer;
    logic              load_out, load_skid, out_from_skid;

    always_comb begin
        form_n = '0;
        case (in_Is[3:2])
            2'b00: form_n[IMM_W+9:0] = {in_Imm, 10'b0};
            2'b01: begin
                form_n              = {DATA_W{in_Imm[IMM_W-1]}};
                form_n[IMM_W-1:0]   = in_Imm;
            end
            default: begin
                case (in_Is[1:0])
                    2'b00: form_n = in_R;
                    2'b01: begin
                        form_n             = {DATA_W{in_Imm[SIMM_W-1]}};
                        form_n[SIMM_W-1:0] = in_Imm[SIMM_W-1:0];
                    end
                    2'b10:   form_n[SHC_W-1:0] = in_R[SHC_W-1:0];
                    default: form_n[SHC_W-1:0] = in_Imm[SHC_W-1:0];
                endcase
            end
        endcase
    end

    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = rdy_q;
    assign out_N     = out_n_q;
    assign out_tag   = out_tag_q;
    assign accept    = in_valid & rdy_q;
    assign xfer      = out_valid & out_ready;

    always_comb begin
        state_d       = state_q;
        load_out      = 1'b0;
        load_skid     = 1'b0;
        out_from_skid = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d  = ST_ONE;
                    load_out = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && xfer) begin
                    load_out = 1'b1;
                end else if (accept) begin
                    state_d   = ST_TWO;
                    load_skid = 1'b1;
                end else if (xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (xfer) begin
                    state_d       = ST_ONE;
                    load_out      = 1'b1;
                    out_from_skid = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush wins over any same-cycle accept or transfer.
        if (flush) begin
            state_d   = ST_EMPTY;
            load_out  = 1'b0;
            load_skid = 1'b0;
        end
        rdy_d = (state_d != ST_TWO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            rdy_q      <= 1'b0;
            out_n_q    <= '0;
            out_tag_q  <= '0;
            skid_n_q   <= '0;
            skid_tag_q <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            if (load_out) begin
                out_n_q   <= out_from_skid ? skid_n_q   : form_n;
                out_tag_q <= out_from_skid ? skid_tag_q : in_tag;
            end
            if (load_skid) begin
                skid_n_q   <= form_n;
                skid_tag_q <= in_tag;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_operand2_pipe.sv
// ============================================================================
// Module      : tb_operand2_pipe
// Description : Directed self-checking bench for operand2_pipe (32- and 64-bit).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_operand2_pipe;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_R;
    logic [21:0] in_Imm;
    logic [3:0]  in_Is;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_N;
    logic [3:0]  out_tag;

    logic        w_valid;
    logic        w_in_ready;
    logic [63:0] w_R;
    logic [21:0] w_Imm;
    logic [3:0]  w_Is;
    logic [3:0]  w_tag;
    logic        w_out_valid;
    logic [63:0] w_N;
    logic [3:0]  w_out_tag;

    int n_tests = 0;
    int n_fail  = 0;

    operand2_pipe dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_R(in_R), .in_Imm(in_Imm), .in_Is(in_Is), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_N(out_N), .out_tag(out_tag)
    );

    operand2_pipe #(.DATA_W(64), .SHC_W(6)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .in_valid(w_valid), .in_ready(w_in_ready),
        .in_R(w_R), .in_Imm(w_Imm), .in_Is(w_Is), .in_tag(w_tag),
        .out_valid(w_out_valid), .out_ready(1'b1),
        .out_N(w_N), .out_tag(w_out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  is;
        logic [31:0] r;
        logic [21:0] imm;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [3:0] is, input logic [31:0] r,
                        input logic [21:0] imm, input logic [3:0] tag);
        in_valid = 1'b1;
        in_Is    = is;
        in_R     = r;
        in_Imm   = imm;
        in_tag   = tag;
    endtask

    initial begin
        vecs[0]  = '{4'b0000, 32'h0,        22'h3FFFFF, 32'hFFFFFC00};
        vecs[1]  = '{4'b0100, 32'h0,        22'h200000, 32'hFFE00000};
        vecs[2]  = '{4'b1001, 32'h0,        22'h001000, 32'hFFFFF000};
        vecs[3]  = '{4'b1010, 32'hDEADBEEF, 22'h0,      32'h0000000F};
        vecs[4]  = '{4'b1000, 32'h12345678, 22'h0,      32'h12345678};
        vecs[5]  = '{4'b0011, 32'hFFFFFFFF, 22'h000001, 32'h00000400};
        vecs[6]  = '{4'b0111, 32'h0,        22'h1FFFFF, 32'h001FFFFF};
        vecs[7]  = '{4'b1100, 32'hCAFEF00D, 22'h3FFFFF, 32'hCAFEF00D};
        vecs[8]  = '{4'b1101, 32'h0,        22'h3FEFFF, 32'h00000FFF};
        vecs[9]  = '{4'b1110, 32'h0000003F, 22'h0,      32'h0000001F};
        vecs[10] = '{4'b1111, 32'h0,        22'h3FFFFF, 32'h0000001F};
        vecs[11] = '{4'b1011, 32'hFFFFFFFF, 22'h000015, 32'h00000015};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_R = '0; in_Imm = '0; in_Is = '0; in_tag = '0;
        w_valid = 1'b0; w_R = '0; w_Imm = '0; w_Is = '0; w_tag = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready",  64'(in_ready),  64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_N",     64'(out_N),     64'd0);
        check("rst_out_tag",   64'(out_tag),   64'd0);
        rst_n = 1'b1;
        #1 check("rel_in_ready_before_edge", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("rel_in_ready_after_edge", 64'(in_ready), 64'd1);

        // Formation table, back-to-back with out_ready=1
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            send(vecs[i].is, vecs[i].r, vecs[i].imm, 4'(i));
            @(negedge clk);
            check($sformatf("form%0d_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("form%0d_N", i),     64'(out_N),     64'(vecs[i].exp));
            check($sformatf("form%0d_tag", i),   64'(out_tag),   64'(i));
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("form_drain_valid", 64'(out_valid), 64'd0);

        // Backpressure: tags 1,2,3 with out_ready low
        out_ready = 1'b0;
        send(4'b1000, 32'h11, 22'h0, 4'd1);
        @(negedge clk);
        check("bp_ready_after1", 64'(in_ready), 64'd1);
        send(4'b1000, 32'h22, 22'h0, 4'd2);
        @(negedge clk);
        check("bp_ready_after2", 64'(in_ready), 64'd0);
        check("bp_hold_tag1",    64'(out_tag),  64'd1);
        send(4'b1000, 32'h33, 22'h0, 4'd3);
        @(negedge clk);
        check("bp_still_full",   64'(in_ready), 64'd0);
        check("bp_stable_tag1",  64'(out_tag),  64'd1);
        check("bp_stable_N1",    64'(out_N),    64'h11);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_out_tag2",     64'(out_tag),  64'd2);
        check("bp_out_N2",       64'(out_N),    64'h22);
        check("bp_ready_again",  64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_out_tag3",     64'(out_tag),  64'd3);
        check("bp_out_N3",       64'(out_N),    64'h33);
        @(negedge clk);
        check("bp_drained",      64'(out_valid), 64'd0);

        // Throughput: 16 beats, one output per cycle after one cycle of latency
        for (int i = 0; i <= 16; i++) begin
            if (i > 0) begin
                check($sformatf("tp%0d_valid", i - 1), 64'(out_valid), 64'd1);
                check($sformatf("tp%0d_N", i - 1),     64'(out_N),     64'(100 + i - 1));
            end
            if (i < 16) send(4'b1000, 32'(100 + i), 22'h0, 4'(i));
            else        in_valid = 1'b0;
            @(negedge clk);
        end
        check("tp_drained", 64'(out_valid), 64'd0);

        // Flush from full with a same-cycle input beat
        out_ready = 1'b0;
        send(4'b1000, 32'hA5, 22'h0, 4'd5);
        @(negedge clk);
        send(4'b1000, 32'hA6, 22'h0, 4'd6);
        @(negedge clk);
        check("fl_full", 64'(in_ready), 64'd0);
        flush = 1'b1;
        send(4'b1000, 32'hA7, 22'h0, 4'd7);
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("fl_out_valid", 64'(out_valid), 64'd0);
        check("fl_in_ready",  64'(in_ready),  64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("fl_quiet%0d", i), 64'(out_valid), 64'd0);
        end

        // Asynchronous reset while full
        out_ready = 1'b0;
        send(4'b1000, 32'hB1, 22'h0, 4'd9);
        @(negedge clk);
        send(4'b1000, 32'hB2, 22'h0, 4'd10);
        @(negedge clk);
        send(4'b1000, 32'hB3, 22'h0, 4'd11);
        check("ar_full_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_out_valid", 64'(out_valid), 64'd0);
        check("ar_out_N",     64'(out_N),     64'd0);
        check("ar_out_tag",   64'(out_tag),   64'd0);
        check("ar_in_ready",  64'(in_ready),  64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("ar_ready_held_low", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("ar_ready_after_edge", 64'(in_ready),  64'd1);
        check("ar_empty_after",      64'(out_valid), 64'd0);

        // 64-bit instance
        w_valid = 1'b1; w_Is = 4'b1011; w_Imm = 22'h3FFFFF; w_tag = 4'd1;
        @(negedge clk);
        check("w64_shc_imm", w_N, 64'h000000000000003F);
        w_Is = 4'b0000; w_tag = 4'd2;
        @(negedge clk);
        check("w64_imm_hi",  w_N, 64'h00000000FFFFFC00);
        check("w64_tag",     64'(w_out_tag), 64'd2);
        w_valid = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
